ones_frame_stats: RTL and testbench

Downstream consumer of the combinational 16-bit ones-count stage. It accepts a stream of 5-bit popcount results over a valid/ready handshake and groups them into frames of FRAME_LEN words. For each frame it produces the sum, maximum and minimum popcount and offers them over a second valid/ready handshake. It sits between the popcount datapath and the board-level result register/display logic.

---
 rtl/ones_pkg.sv | 16 +
 rtl/ones_frame_stats_if.sv | 32 +++
 rtl/ones_minmax_acc.sv | 34 +++
 rtl/ones_frame_stats.sv | 157 +++++++++++++++
 tb/tb_ones_frame_stats.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ones_pkg.sv
// ones_pkg: shared constants and FSM encoding for the ones-count frame
// statistics block.
//   ONES_MAX : largest legal popcount of a 16-bit word
//   COUNT_W  : width of one popcount value
//   state_t  : two-state frame FSM (accumulating / holding a result)
package ones_pkg;

    localparam int ONES_MAX = 16;
    localparam int COUNT_W  = 5;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/ones_frame_stats_if.sv
// ones_frame_stats_if: groups the popcount input handshake, the frame result
// handshake and the synchronous clear.
//   master : producer/consumer side (drives clear, in_*, out_ready)
//   slave  : the ones_frame_stats block (drives in_ready, out_*)
interface ones_frame_stats_if
    import ones_pkg::*;
#(
    parameter int SUM_W = 8
);

    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [COUNT_W-1:0] in_count;
    logic               out_valid;
    logic               out_ready;
    logic [SUM_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_max;
    logic [COUNT_W-1:0] out_min;
    logic               out_err;

    modport master (
        output clear, in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_min, out_err
    );

    modport slave (
        input  clear, in_valid, in_count, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_min, out_err
    );

endinterface

// File: rtl/ones_minmax_acc.sv
// ones_minmax_acc: combinational next-value logic for the frame accumulators.
// Clamps the incoming popcount to ONES_MAX and folds it into the running
// sum, maximum and minimum; flags counts above ONES_MAX.
//   in_count          : incoming popcount (may be illegal, > ONES_MAX)
//   acc_sum/max/min/err : current accumulator values
//   nxt_sum/max/min/err : accumulator values including this word
module ones_minmax_acc
    import ones_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic [COUNT_W-1:0] in_count,
    input  logic [SUM_W-1:0]   acc_sum,
    input  logic [COUNT_W-1:0] acc_max,
    input  logic [COUNT_W-1:0] acc_min,
    input  logic               acc_err,
    output logic [SUM_W-1:0]   nxt_sum,
    output logic [COUNT_W-1:0] nxt_max,
    output logic [COUNT_W-1:0] nxt_min,
    output logic               nxt_err
);

    logic               illegal;
    logic [COUNT_W-1:0] val;

    assign illegal = in_count > COUNT_W'(ONES_MAX);
    assign val     = illegal ? COUNT_W'(ONES_MAX) : in_count;

    assign nxt_sum = acc_sum + SUM_W'(val);
    assign nxt_max = (val > acc_max) ? val : acc_max;
    assign nxt_min = (val < acc_min) ? val : acc_min;
    assign nxt_err = acc_err | illegal;

endmodule

// File: rtl/ones_frame_stats.sv
// ones_frame_stats: groups a stream of popcounts into frames of FRAME_LEN
// words and offers sum / max / min / error flag per frame.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ones_frame_stats_if (clear, input and result
//           handshakes)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ACCUM | in_ready=1, accepting words into the accumulators
// ST_HOLD  | out_valid=1, frame result held until out_ready
module ones_frame_stats
    import ones_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN),
    parameter int SUM_W     = COUNT_W + CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ones_frame_stats_if.slave        bus
);

    localparam logic [COUNT_W-1:0] MIN_INIT = COUNT_W'(ONES_MAX);
    localparam logic [CNT_W-1:0]   IDX_LAST = CNT_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic [COUNT_W-1:0] out_max_q, out_max_d;
    logic [COUNT_W-1:0] out_min_q, out_min_d;
    logic               out_err_q, out_err_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [SUM_W-1:0]   acc_sum_q, acc_sum_d;
    logic [COUNT_W-1:0] acc_max_q, acc_max_d;
    logic [COUNT_W-1:0] acc_min_q, acc_min_d;
    logic               acc_err_q, acc_err_d;

    logic [SUM_W-1:0]   nxt_sum;
    logic [COUNT_W-1:0] nxt_max;
    logic [COUNT_W-1:0] nxt_min;
    logic               nxt_err;
    logic               accept;

    ones_minmax_acc #(
        .SUM_W (SUM_W)
    ) u_acc (
        .in_count (bus.in_count),
        .acc_sum  (acc_sum_q),
        .acc_max  (acc_max_q),
        .acc_min  (acc_min_q),
        .acc_err  (acc_err_q),
        .nxt_sum  (nxt_sum),
        .nxt_max  (nxt_max),
        .nxt_min  (nxt_min),
        .nxt_err  (nxt_err)
    );

    // in_ready_q is only ever high in ST_ACCUM
    assign accept = bus.in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_sum_d = acc_sum_q;
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;
        acc_err_d = acc_err_q;
        out_sum_d = out_sum_q;
        out_max_d = out_max_q;
        out_min_d = out_min_q;
        out_err_d = out_err_q;

        if (bus.clear) begin
            // result data registers deliberately keep their old contents
            state_d   = ST_ACCUM;
            idx_d     = '0;
            acc_sum_d = '0;
            acc_max_d = '0;
            acc_min_d = MIN_INIT;
            acc_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (idx_q == IDX_LAST) begin
                            out_sum_d = nxt_sum;
                            out_max_d = nxt_max;
                            out_min_d = nxt_min;
                            out_err_d = nxt_err;
                            idx_d     = '0;
                            acc_sum_d = '0;
                            acc_max_d = '0;
                            acc_min_d = MIN_INIT;
                            acc_err_d = 1'b0;
                            state_d   = ST_HOLD;
                        end else begin
                            acc_sum_d = nxt_sum;
                            acc_max_d = nxt_max;
                            acc_min_d = nxt_min;
                            acc_err_d = nxt_err;
                            idx_d     = idx_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d = ST_ACCUM;
                    end
                end
            endcase
        end

        // handshake flags follow the next state so they are registered
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_err_q   <= 1'b0;
            idx_q       <= '0;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= MIN_INIT;
            acc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_err_q   <= out_err_d;
            idx_q       <= idx_d;
            acc_sum_q   <= acc_sum_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            acc_err_q   <= acc_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ones_frame_stats.sv
// tb_ones_frame_stats: self-checking bench for ones_frame_stats. Table of
// directed frames, hand-written clear/reset sequences, then random frames
// checked against a clamp/sum/max/min reference model.
module tb_ones_frame_stats;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   last_sum = 0;

    ones_frame_stats_if #(.SUM_W(8)) bus ();

    ones_frame_stats dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [39:0] words;
        int          hold;
        int          sum;
        int          mx;
        int          mn;
        int          err;
    } vec_t;

    function automatic logic [39:0] pack8(input int a, input int b, input int c, input int d,
                                          input int e, input int f, input int g, input int h);
        logic [39:0] r;
        r = {h[4:0], g[4:0], f[4:0], e[4:0], d[4:0], c[4:0], b[4:0], a[4:0]};
        return r;
    endfunction

    function automatic logic [39:0] fill8(input int v);
        return pack8(v, v, v, v, v, v, v, v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_word(input logic [4:0] w);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_count = w;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", int'(guard < 50), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] words, input int gap_max);
        int gap;
        for (int i = 0; i < 8; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) @(negedge clk);
            if (i == 7) check("pre_valid", int'(bus.out_valid), 0);
            send_word(words[i*5 +: 5]);
        end
    endtask

    task automatic expect_result(input string name, input int esum, input int emax,
                                 input int emin, input int eerr, input int hold);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_sum"}, int'(bus.out_sum), esum);
        check({name, "_max"}, int'(bus.out_max), emax);
        check({name, "_min"}, int'(bus.out_min), emin);
        check({name, "_err"}, int'(bus.out_err), eerr);
        check({name, "_in_ready"}, int'(bus.in_ready), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, int'(bus.out_valid), 1);
            check({name, "_hold_sum"}, int'(bus.out_sum), esum);
            check({name, "_hold_minmax"}, int'({bus.out_max, bus.out_min}), (emax << 5) | emin);
            check({name, "_hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_drop_valid"}, int'(bus.out_valid), 0);
        check({name, "_ready_back"}, int'(bus.in_ready), 1);
        last_sum = esum;
    endtask

    // called at a negedge: reset lands between clock edges
    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_rst_valid"}, int'(bus.out_valid), 0);
        check({name, "_rst_in_ready"}, int'(bus.in_ready), 1);
        check({name, "_rst_sum"}, int'(bus.out_sum), 0);
        check({name, "_rst_maxmin"}, int'({bus.out_max, bus.out_min}), 0);
        check({name, "_rst_err"}, int'(bus.out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        logic [39:0] rw;
        int q[$];
        int msum, mmax, mmin, merr, v, w;

        vecs[0] = '{"frame_a", pack8(16, 12, 14, 1, 9, 6, 10, 0), 0, 68, 16, 0, 0};
        vecs[1] = '{"frame_a_bp", pack8(16, 12, 14, 1, 9, 6, 10, 0), 5, 68, 16, 0, 0};
        vecs[2] = '{"all16", fill8(16), 0, 128, 16, 16, 0};
        vecs[3] = '{"all0", fill8(0), 1, 0, 0, 0, 0};
        vecs[4] = '{"illegal", pack8(5, 5, 5, 31, 5, 5, 5, 5), 0, 51, 16, 5, 1};
        vecs[5] = '{"clean5", fill8(5), 2, 40, 5, 5, 0};

        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_sum", int'(bus.out_sum), 0);
        check("reset_max", int'(bus.out_max), 0);
        check("reset_min", int'(bus.out_min), 0);
        check("reset_err", int'(bus.out_err), 0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].words, 0);
            expect_result(vecs[i].name, vecs[i].sum, vecs[i].mx, vecs[i].mn,
                          vecs[i].err, vecs[i].hold);
        end

        // clear mid-frame together with an offered word
        for (int i = 0; i < 4; i++) send_word(5'd7);
        bus.in_valid = 1'b1;
        bus.in_count = 5'd9;
        bus.clear    = 1'b1;
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_valid", int'(bus.out_valid), 0);
        check("clr_in_ready", int'(bus.in_ready), 1);
        check("clr_keep_sum", int'(bus.out_sum), last_sum);
        send_frame(fill8(2), 0);
        expect_result("after_clear", 16, 2, 2, 0, 0);

        // clear while holding a result, with out_ready also high
        send_frame(fill8(3), 0);
        check("hold_clr_pre", int'(bus.out_valid), 1);
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        check("hold_clr_valid", int'(bus.out_valid), 0);
        check("hold_clr_in_ready", int'(bus.in_ready), 1);
        check("hold_clr_keep_sum", int'(bus.out_sum), 24);
        send_frame(fill8(1), 0);
        expect_result("after_hold_clear", 8, 1, 1, 0, 0);

        // async reset mid-frame then in HOLD
        for (int i = 0; i < 3; i++) send_word(5'd9);
        async_reset("mid");
        send_frame(fill8(4), 0);
        expect_result("after_mid_rst", 32, 4, 4, 0, 0);
        send_frame(fill8(15), 0);
        check("hold_rst_pre", int'(bus.out_valid), 1);
        async_reset("hold");
        send_frame(pack8(3, 8, 1, 16, 2, 0, 4, 7), 0);
        expect_result("after_hold_rst", 41, 16, 0, 0, 0);

        // random frames against a reference model
        for (int f = 0; f < 25; f++) begin
            q.delete();
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) < 2) w = int'($urandom_range(17, 31));
                else                          w = int'($urandom_range(0, 16));
                q.push_back(w);
                rw[i*5 +: 5] = w[4:0];
            end
            msum = 0; mmax = 0; mmin = 16; merr = 0;
            foreach (q[i]) begin
                v = (q[i] > 16) ? 16 : q[i];
                msum += v;
                if (v > mmax) mmax = v;
                if (v < mmin) mmin = v;
                if (q[i] > 16) merr = 1;
            end
            send_frame(rw, 2);
            expect_result("rand", msum, mmax, mmin, merr, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
